dphy_hs_lane_tx: RTL and testbench

Single-lane D-PHY high-speed byte transmitter. It takes packet bytes over a valid/ready stream and emits one HS burst per packet: HS-zero leader, sync byte 0xB8, payload, then a D-PHY trailer. It sits between the CSI-2 packet builder and the lane serializer. It is the transmit counterpart of the lane byte aligner, and is also used in benches to drive the receive path.

---
 rtl/dphy_hs_lane_tx.sv | 203 ++++++++++++++++++++
 tb/tb_dphy_hs_lane_tx.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dphy_hs_lane_tx.sv
// dphy_hs_lane_tx
// Single-lane D-PHY high-speed byte transmitter. Each packet taken from the
// valid/ready stream becomes one HS burst: HS-zero leader, sync byte 0xB8,
// payload bytes, then trailer bytes that invert the last transmitted bit.
// Optional build macro: DPHY_TX_SKEW_EN adds a skew_i port that delays the
// emitted bitstream by 0..7 bit times (used to exercise receive aligners).
module dphy_hs_lane_tx #(
    parameter int PREAMBLE_BYTES = 2,  // 1..15
    parameter int TRAILER_BYTES  = 2   // 1..15
) (
    input  logic       clk_i,
    input  logic       rst_i,
`ifdef DPHY_TX_SKEW_EN
    input  logic [2:0] skew_i,
`endif
    input  logic       s_valid_i,
    input  logic [7:0] s_data_i,
    input  logic       s_last_i,
    output logic       s_ready_o,
    output logic       hs_en_o,
    output logic [7:0] hs_byte_o,
    output logic       busy_o,
    output logic       underflow_o
);

    localparam logic [7:0] SYNC_BYTE  = 8'hB8;
    localparam logic [3:0] ZERO_LOAD  = 4'(PREAMBLE_BYTES - 1);
    localparam logic [3:0] TRAIL_LOAD = 4'(TRAILER_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ZERO,
        ST_SYNC,
        ST_DATA,
        ST_TRAIL
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;        // preamble / trailer byte counter
    logic [7:0] data_q, data_d;      // byte accepted last cycle, emitted this cycle
    logic       pend_q, pend_d;      // last payload byte still waiting to go out
    logic       b7_q, b7_d;          // bit 7 of the most recent byte on the wire
    logic       hs_en_d;
    logic       underflow_d;
    logic [7:0] raw_byte;            // unshifted byte for the next output edge
    logic [7:0] out_byte;            // byte actually registered onto hs_byte_o

    // Handshake qualifier is purely state-decoded so the upstream never sees a
    // combinational path from its own valid back to ready.
    assign s_ready_o = (state_q == ST_SYNC) || (state_q == ST_DATA);
    assign busy_o    = (state_q != ST_IDLE);

    // Next-state and next-output decode for the burst sequencer.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        pend_d      = pend_q;
        b7_d        = b7_q;
        hs_en_d     = 1'b0;
        raw_byte    = 8'h00;
        underflow_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The one IDLE cycle after a burst is the LP exit gap: hs_en
                // drops for that edge and the pending byte is not consumed.
                pend_d = 1'b0;
                if (s_valid_i) begin
                    state_d = ST_ZERO;
                    cnt_d   = ZERO_LOAD;
                end
            end

            ST_ZERO: begin
                hs_en_d  = 1'b1;
                raw_byte = 8'h00;
                if (cnt_q == 4'd0) begin
                    state_d = ST_SYNC;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_SYNC: begin
                hs_en_d  = 1'b1;
                raw_byte = SYNC_BYTE;
                b7_d     = SYNC_BYTE[7];
                cnt_d    = TRAIL_LOAD;
                if (s_valid_i) begin
                    data_d = s_data_i;
                    if (s_last_i) begin
                        state_d = ST_TRAIL;
                        pend_d  = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    // HS cannot stall: a missing first byte truncates the packet.
                    underflow_d = 1'b1;
                    state_d     = ST_TRAIL;
                end
            end

            ST_DATA: begin
                // Every DATA cycle emits the byte accepted on the previous edge.
                hs_en_d  = 1'b1;
                raw_byte = data_q;
                b7_d     = data_q[7];
                cnt_d    = TRAIL_LOAD;
                if (s_valid_i) begin
                    data_d = s_data_i;
                    if (s_last_i) begin
                        state_d = ST_TRAIL;
                        pend_d  = 1'b1;
                    end
                end else begin
                    underflow_d = 1'b1;
                    state_d     = ST_TRAIL;
                end
            end

            ST_TRAIL: begin
                hs_en_d = 1'b1;
                if (pend_q) begin
                    // Flush the final payload byte before the first trailer byte.
                    raw_byte = data_q;
                    b7_d     = data_q[7];
                    pend_d   = 1'b0;
                end else begin
                    raw_byte = {8{~b7_q}};
                    if (cnt_q == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef DPHY_TX_SKEW_EN
    logic [2:0]  skew_q;
    logic [7:0]  prev_q;             // previous unshifted byte, 0 while idle
    logic [15:0] pair;
    logic [3:0]  shift_amt;

    // Bit-delay the stream: take the window of the {current, previous} pair
    // that lags the byte boundary by skew bits.
    always_comb begin
        pair      = {raw_byte, prev_q};
        shift_amt = 4'd8 - {1'b0, skew_q};
        out_byte  = 8'(pair >> shift_amt);
    end

    // Capture the skew at burst start and track the previous unshifted byte.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skew_q <= 3'd0;
            prev_q <= 8'h00;
        end else begin
            if ((state_q == ST_IDLE) && s_valid_i) begin
                skew_q <= skew_i;
            end
            prev_q <= raw_byte;
        end
    end
`else
    assign out_byte = raw_byte;
`endif

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            data_q      <= 8'h00;
            pend_q      <= 1'b0;
            b7_q        <= 1'b0;
            hs_en_o     <= 1'b0;
            hs_byte_o   <= 8'h00;
            underflow_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            pend_q      <= pend_d;
            b7_q        <= b7_d;
            hs_en_o     <= hs_en_d;
            hs_byte_o   <= out_byte;
            underflow_o <= underflow_d;
        end
    end

endmodule

// File: tb/tb_dphy_hs_lane_tx.sv
// Testbench for dphy_hs_lane_tx: scoreboard of expected HS bytes, filled when
// a packet is driven and drained by a monitor on the falling clock edge.
`timescale 1ns/1ps
module tb_dphy_hs_lane_tx;

    localparam int PRE = 2;
    localparam int TRL = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic       hs_en;
    logic [7:0] hs_byte;
    logic       busy;
    logic       underflow;
`ifdef DPHY_TX_SKEW_EN
    logic [2:0] skew = 3'd0;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] pkt[16];
    logic [7:0] mon_exp;

    int cyc             = 0;
    int uf_count        = 0;
    int ready_count     = 0;
    int low_run         = 0;
    int last_gap        = -1;
    bit seen_burst      = 1'b0;
    int burst_start_cyc = 0;
    int valid_cyc       = 0;

    dphy_hs_lane_tx #(
        .PREAMBLE_BYTES(PRE),
        .TRAILER_BYTES (TRL)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
`ifdef DPHY_TX_SKEW_EN
        .skew_i     (skew),
`endif
        .s_valid_i  (s_valid),
        .s_data_i   (s_data),
        .s_last_i   (s_last),
        .s_ready_o  (s_ready),
        .hs_en_o    (hs_en),
        .hs_byte_o  (hs_byte),
        .busy_o     (busy),
        .underflow_o(underflow)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compare every HS byte against the scoreboard, track gaps,
    // underflow pulses and ready cycles.
    initial forever begin
        @(negedge clk);
        if (underflow === 1'b1) uf_count++;
        if (s_ready === 1'b1) ready_count++;
        if (hs_en === 1'b1) begin
            if (!seen_burst || low_run > 0) begin
                burst_start_cyc = cyc;
                if (seen_burst) last_gap = low_run;
            end
            seen_burst = 1'b1;
            low_run    = 0;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL hs_byte_extra: got %02h, scoreboard empty", hs_byte);
            end else begin
                mon_exp = exp_q.pop_front();
                if (hs_byte !== mon_exp) begin
                    failures++;
                    $display("FAIL hs_byte: got %02h, expected %02h (cycle %0d)", hs_byte, mon_exp, cyc);
                end
            end
        end else if (seen_burst) begin
            low_run++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Expected burst for pkt[0..n_sent-1], delayed by sk bits on the wire.
    task automatic push_burst(input int n_sent, input int sk);
        logic [7:0] u[$];
        logic [7:0] prev;
        logic [7:0] o;
        logic       b7;
        for (int i = 0; i < PRE; i++) u.push_back(8'h00);
        u.push_back(8'hB8);
        b7 = 1'b1;
        for (int i = 0; i < n_sent; i++) begin
            u.push_back(pkt[i]);
            b7 = pkt[i][7];
        end
        for (int i = 0; i < TRL; i++) u.push_back({8{~b7}});
        prev = 8'h00;
        foreach (u[k]) begin
            if (sk == 0) o = u[k];
            else o = (u[k] << sk) | (prev >> (8 - sk));
            exp_q.push_back(o);
            prev = u[k];
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (s_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: s_ready not seen within 50 cycles");
        end
    endtask

    // Drive pkt[0..n-1]; stop driving valid before byte index drop_after.
    task automatic send_packet(input int n, input int drop_after, input bit keep_valid);
        bit ok;
        for (int i = 0; i < n; i++) begin
            if (i == drop_after) break;
            s_valid = 1'b1;
            s_data  = pkt[i];
            s_last  = (i == n - 1);
            if (i == 0) valid_cyc = cyc;
            wait_ready(ok);
            if (!ok) break;
            @(posedge clk);
            #1;
        end
        if (!keep_valid) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag);
        bit done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busy === 1'b0 && hs_en === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_end: idle=%0d leftover=%0d, expected idle=1 leftover=0",
                     tag, done, exp_q.size());
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (s_ready !== 1'b0 || hs_en !== 1'b0 || hs_byte !== 8'h00 ||
            busy !== 1'b0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL %s: ready=%b en=%b byte=%02h busy=%b uf=%b, expected 0 0 00 0 0",
                     tag, s_ready, hs_en, hs_byte, busy, underflow);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("idle_after_reset");
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int uf0;
        uf0 = uf_count;
        pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h83;
        push_burst(3, 0);
        send_packet(3, 99, 1'b0);
        wait_done("basic");
        checks++;
        if (uf_count - uf0 != 0) begin
            failures++;
            $display("FAIL basic_underflow: pulses=%0d, expected 0", uf_count - uf0);
        end
        checks++;
        if (burst_start_cyc - valid_cyc != 2) begin
            failures++;
            $display("FAIL basic_hs_start: edges=%0d, expected 2", burst_start_cyc - valid_cyc);
        end
    endtask

    task automatic test_trailer_ones();
        int rc0;
        rc0 = ready_count;
        pkt[0] = 8'h01; pkt[1] = 8'h7F;
        push_burst(2, 0);
        send_packet(2, 99, 1'b0);
        wait_done("trailer_ones");
        checks++;
        if (ready_count - rc0 != 2) begin
            failures++;
            $display("FAIL ready_cycles: got %0d, expected 2", ready_count - rc0);
        end
    endtask

    task automatic test_underflow();
        int uf0;
        uf0 = uf_count;
        pkt[0] = 8'h3C; pkt[1] = 8'h44; pkt[2] = 8'h55; pkt[3] = 8'h66;
        push_burst(1, 0);
        send_packet(4, 1, 1'b0);
        wait_done("underflow");
        checks++;
        if (uf_count - uf0 != 1) begin
            failures++;
            $display("FAIL underflow_pulses: got %0d, expected 1", uf_count - uf0);
        end
    endtask

    task automatic test_back_to_back();
        pkt[0] = 8'h10; pkt[1] = 8'h9E;
        push_burst(2, 0);
        send_packet(2, 99, 1'b1);
        pkt[0] = 8'h44;
        push_burst(1, 0);
        send_packet(1, 99, 1'b0);
        wait_done("back_to_back");
        checks++;
        if (last_gap != 1) begin
            failures++;
            $display("FAIL lp_gap: hs_en low %0d cycles, expected 1", last_gap);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        for (int i = 0; i < PRE; i++) exp_q.push_back(8'h00);
        exp_q.push_back(8'hB8);
        s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b0;
        wait_ready(ok);
        @(posedge clk);
        #1;
        s_data = 8'h6B;
        wait_ready(ok);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL reset_burst_bytes: leftover=%0d, expected 0", exp_q.size());
        end
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        pkt[0] = 8'h66; pkt[1] = 8'hE7;
        push_burst(2, 0);
        send_packet(2, 99, 1'b0);
        wait_done("after_reset");
    endtask

`ifdef DPHY_TX_SKEW_EN
    task automatic test_skew();
        skew = 3'd3;
        pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h83;
        push_burst(3, 3);
        send_packet(3, 99, 1'b0);
        wait_done("skew3");
        skew = 3'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_trailer_ones();
        test_underflow();
        test_back_to_back();
        test_reset_mid_burst();
`ifdef DPHY_TX_SKEW_EN
        test_skew();
`endif
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
